// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front end: repeat-FSM encoding,
// channel indices and the board-clock timing defaults.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    RPT_IDLE   = 2'd0,
    RPT_DELAY  = 2'd1,
    RPT_REPEAT = 2'd2
  } rpt_state_e;

  // Default timing at the 4 MHz board clock.
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 40000;
  localparam int unsigned DEFAULT_REPEAT_DELAY    = 2000000;
  localparam int unsigned DEFAULT_REPEAT_PERIOD   = 1000000;

  // Auto-repeating channels.
  localparam int unsigned NUM_RPT  = 2;
  localparam int unsigned RPT_UP   = 0;
  localparam int unsigned RPT_DOWN = 1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One raw button: 2-FF synchroniser, persistence-count debouncer and
// rising-edge detect on the debounced level.
module btn_debounce
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned DCNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DEBOUNCE_CYCLES - 1);

  logic              meta_q;
  logic              sync_q;
  logic              stable_q;
  logic              stable_d;
  logic              stable_prev_q;
  logic [DCNT_W-1:0] dcnt_q;
  logic [DCNT_W-1:0] dcnt_d;

  // NOTE: every variable gets a default at the top of always_comb so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    dcnt_d   = '0;
    stable_d = stable_q;
    if (sync_q != stable_q) begin
      if (dcnt_q == DCNT_LAST) begin
        stable_d = sync_q;
      end else begin
        dcnt_d = dcnt_q + DCNT_W'(1);
      end
    end
  end

  // NOTE: the synchroniser flops are reset too, so a button held through
  // reset re-enters as a fresh press rather than as a stale level.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q        <= 1'b0;
      sync_q        <= 1'b0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      dcnt_q        <= '0;
    end else begin
      meta_q        <= raw;
      sync_q        <= meta_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      dcnt_q        <= dcnt_d;
    end
  end

  assign level = stable_q;
  assign rise  = stable_q & ~stable_prev_q;

endmodule

// File: rtl/button_conditioner.sv
// Set/up/down button front end: debounced levels, one-shot press pulses and
// auto-repeat on up/down, with up+down conflicts silenced.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = DEFAULT_REPEAT_DELAY,
  parameter int unsigned REPEAT_PERIOD   = DEFAULT_REPEAT_PERIOD
) (
  input  logic clkBoard,
  input  logic reset,
  input  logic set_raw,
  input  logic up_raw,
  input  logic down_raw,
  output logic set_pulse,
  output logic up_pulse,
  output logic down_pulse,
  output logic set_level,
  output logic up_level,
  output logic down_level
);

  localparam int unsigned RCNT_W = $clog2(max_u(REPEAT_DELAY, REPEAT_PERIOD));
  localparam logic [RCNT_W-1:0] DELAY_LAST  = RCNT_W'(REPEAT_DELAY - 1);
  localparam logic [RCNT_W-1:0] PERIOD_LAST = RCNT_W'(REPEAT_PERIOD - 1);

  logic               set_rise;
  logic [NUM_RPT-1:0] rpt_level;
  logic [NUM_RPT-1:0] rpt_rise;
  logic               conflict;

  rpt_state_e         rpt_state_q [NUM_RPT];
  logic [RCNT_W-1:0]  rcnt_q      [NUM_RPT];
  logic [NUM_RPT-1:0] rpt_pulse_q;
  logic               set_pulse_q;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_set (
    .clk   (clkBoard),
    .rst   (reset),
    .raw   (set_raw),
    .level (set_level),
    .rise  (set_rise)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_up (
    .clk   (clkBoard),
    .rst   (reset),
    .raw   (up_raw),
    .level (rpt_level[RPT_UP]),
    .rise  (rpt_rise[RPT_UP])
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_down (
    .clk   (clkBoard),
    .rst   (reset),
    .raw   (down_raw),
    .level (rpt_level[RPT_DOWN]),
    .rise  (rpt_rise[RPT_DOWN])
  );

  // Both held: neither may scroll, and since the FSMs sit in IDLE the
  // survivor needs a fresh rising edge before it speaks again.
  assign conflict = &rpt_level;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clkBoard) begin
    if (reset) begin
      for (int ch = 0; ch < NUM_RPT; ch++) begin
        rpt_state_q[ch] <= RPT_IDLE;
        rcnt_q[ch]      <= '0;
      end
      rpt_pulse_q <= '0;
      set_pulse_q <= 1'b0;
    end else begin
      set_pulse_q <= set_rise;
      for (int ch = 0; ch < NUM_RPT; ch++) begin
        if (!rpt_level[ch] || conflict) begin
          rpt_state_q[ch] <= RPT_IDLE;
          rcnt_q[ch]      <= '0;
          rpt_pulse_q[ch] <= 1'b0;
        end else begin
          case (rpt_state_q[ch])
            RPT_IDLE: begin
              rcnt_q[ch]      <= '0;
              rpt_pulse_q[ch] <= rpt_rise[ch];
              if (rpt_rise[ch]) begin
                rpt_state_q[ch] <= RPT_DELAY;
              end
            end
            RPT_DELAY: begin
              if (rcnt_q[ch] == DELAY_LAST) begin
                rcnt_q[ch]      <= '0;
                rpt_pulse_q[ch] <= 1'b1;
                rpt_state_q[ch] <= RPT_REPEAT;
              end else begin
                rcnt_q[ch]      <= rcnt_q[ch] + RCNT_W'(1);
                rpt_pulse_q[ch] <= 1'b0;
              end
            end
            RPT_REPEAT: begin
              if (rcnt_q[ch] == PERIOD_LAST) begin
                rcnt_q[ch]      <= '0;
                rpt_pulse_q[ch] <= 1'b1;
              end else begin
                rcnt_q[ch]      <= rcnt_q[ch] + RCNT_W'(1);
                rpt_pulse_q[ch] <= 1'b0;
              end
            end
            default: begin
              rpt_state_q[ch] <= RPT_IDLE;
              rcnt_q[ch]      <= '0;
              rpt_pulse_q[ch] <= 1'b0;
            end
          endcase
        end
      end
    end
  end

  assign set_pulse  = set_pulse_q;
  assign up_pulse   = rpt_pulse_q[RPT_UP];
  assign down_pulse = rpt_pulse_q[RPT_DOWN];
  assign up_level   = rpt_level[RPT_UP];
  assign down_level = rpt_level[RPT_DOWN];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with a window/timestamp reference
// model checked every cycle, plus literal expectations per scenario.
module tb_button_conditioner;

  localparam int D  = 4;
  localparam int RD = 10;
  localparam int RP = 5;

  logic clkBoard = 1'b0;
  logic reset    = 1'b1;
  logic set_raw  = 1'b0;
  logic up_raw   = 1'b0;
  logic down_raw = 1'b0;
  logic set_pulse, up_pulse, down_pulse;
  logic set_level, up_level, down_level;

  button_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clkBoard   (clkBoard),
    .reset      (reset),
    .set_raw    (set_raw),
    .up_raw     (up_raw),
    .down_raw   (down_raw),
    .set_pulse  (set_pulse),
    .up_pulse   (up_pulse),
    .down_pulse (down_pulse),
    .set_level  (set_level),
    .up_level   (up_level),
    .down_level (down_level)
  );

  always #5 clkBoard = ~clkBoard;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state; channel 0=set, 1=up, 2=down.
  bit [15:0] rawh [3];
  bit        stab [3];
  bit        lvl1 [3];
  bit        lvl2 [3];
  bit        act  [3];
  int        t0   [3];
  bit        exp_pulse [3];

  int set_q[$];
  int up_q[$];
  int down_q[$];
  int set_lvl_cnt  = 0;
  int up_lvl_cnt   = 0;
  int down_lvl_cnt = 0;

  task automatic check(input string name, input int act_v, input int exp_v);
    n_checks++;
    if (act_v !== exp_v) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0d, expected %0d", name, cyc, act_v, exp_v);
    end
  endtask

  function automatic int count_since(input int q[$], input int s);
    int n = 0;
    foreach (q[i]) if (q[i] > s) n++;
    return n;
  endfunction

  function automatic int nth_since(input int q[$], input int s, input int n);
    int k = 0;
    foreach (q[i]) begin
      if (q[i] > s) begin
        if (k == n) return q[i];
        k++;
      end
    end
    return -1;
  endfunction

  // One clock edge: sample inputs, advance the model, compare every output.
  task automatic tick();
    bit r_in [3];
    bit rst_in;
    bit conflict;
    bit flip;
    int d;
    @(posedge clkBoard);
    cyc++;
    rst_in  = reset;
    r_in[0] = set_raw;
    r_in[1] = up_raw;
    r_in[2] = down_raw;
    #1;
    if (rst_in) begin
      for (int c = 0; c < 3; c++) begin
        rawh[c] = '0; stab[c] = 0; lvl1[c] = 0; lvl2[c] = 0;
        act[c] = 0; exp_pulse[c] = 0;
      end
    end else begin
      // Pulses are decided from levels as they stood before this edge.
      conflict     = lvl1[1] & lvl1[2];
      exp_pulse[0] = lvl1[0] & ~lvl2[0];
      for (int c = 1; c < 3; c++) begin
        if (!lvl1[c] || conflict) begin
          act[c] = 0;
          exp_pulse[c] = 0;
        end else if (!lvl2[c]) begin
          act[c] = 1;
          t0[c] = cyc;
          exp_pulse[c] = 1;
        end else if (act[c]) begin
          d = cyc - t0[c];
          exp_pulse[c] = (d == RD) || (d > RD && ((d - RD) % RP) == 0);
        end else begin
          exp_pulse[c] = 0;
        end
      end
      // Level flips once the last D synchronised samples all disagree with it.
      for (int c = 0; c < 3; c++) begin
        flip = 1;
        for (int j = 1; j <= D; j++) if (rawh[c][j] == stab[c]) flip = 0;
        if (flip) stab[c] = ~stab[c];
        rawh[c] = {rawh[c][14:0], r_in[c]};
        lvl2[c] = lvl1[c];
        lvl1[c] = stab[c];
      end
    end
    check("set_level",  int'(set_level),  int'(stab[0]));
    check("up_level",   int'(up_level),   int'(stab[1]));
    check("down_level", int'(down_level), int'(stab[2]));
    check("set_pulse",  int'(set_pulse),  int'(exp_pulse[0]));
    check("up_pulse",   int'(up_pulse),   int'(exp_pulse[1]));
    check("down_pulse", int'(down_pulse), int'(exp_pulse[2]));
    if (set_pulse === 1'b1)  set_q.push_back(cyc);
    if (up_pulse === 1'b1)   up_q.push_back(cyc);
    if (down_pulse === 1'b1) down_q.push_back(cyc);
    if (set_level === 1'b1)  set_lvl_cnt++;
    if (up_level === 1'b1)   up_lvl_cnt++;
    if (down_level === 1'b1) down_lvl_cnt++;
    @(negedge clkBoard);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_outs"}, int'({set_pulse, up_pulse, down_pulse,
                                set_level, up_level, down_level}), 0);
  endtask

  initial begin
    int s;
    int snap;
    int r_end;

    // Reset state.
    reset = 1'b1;
    ticks(2);
    check_all_zero("reset");
    reset = 1'b0;
    ticks(3);

    // 1: bouncing up input, then a clean 8-cycle hold.
    s = cyc;
    snap = up_lvl_cnt;
    for (int i = 0; i < 20; i++) begin
      up_raw = ((i % 4) < 2);
      tick();
    end
    up_raw = 1'b1;
    ticks(8);
    up_raw = 1'b0;
    ticks(20);
    check("s1_up_pulse_count", count_since(up_q, s), 1);
    check("s1_up_pulse_time", nth_since(up_q, s, 0), s + 27);
    check("s1_up_level_cycles", up_lvl_cnt - snap, 8);
    check("s1_up_level_after", int'(up_level), 0);

    // 2: up held 40 cycles -> press, delay, then periodic repeats.
    s = cyc;
    up_raw = 1'b1;
    ticks(40);
    up_raw = 1'b0;
    ticks(30);
    check("s2_up_pulse_count", count_since(up_q, s), 7);
    check("s2_first_pulse", nth_since(up_q, s, 0), s + 7);
    check("s2_first_repeat", nth_since(up_q, s, 1), s + 17);
    check("s2_second_repeat", nth_since(up_q, s, 2), s + 22);
    check("s2_last_repeat", nth_since(up_q, s, 6), s + 42);

    // 3: set held 50 cycles -> single pulse, level high for 50 cycles.
    s = cyc;
    snap = set_lvl_cnt;
    set_raw = 1'b1;
    ticks(50);
    set_raw = 1'b0;
    ticks(20);
    check("s3_set_pulse_count", count_since(set_q, s), 1);
    check("s3_set_pulse_time", nth_since(set_q, s, 0), s + 7);
    check("s3_set_level_cycles", set_lvl_cnt - snap, 50);

    // 4: up and down together, then down released -> silence throughout.
    s = cyc;
    snap = up_lvl_cnt;
    up_raw = 1'b1;
    down_raw = 1'b1;
    ticks(30);
    down_raw = 1'b0;
    ticks(20);
    up_raw = 1'b0;
    ticks(20);
    check("s4_up_pulse_count", count_since(up_q, s), 0);
    check("s4_down_pulse_count", count_since(down_q, s), 0);
    check("s4_up_level_cycles", up_lvl_cnt - snap, 50);

    // 5: reset while up is repeating, button held through reset.
    s = cyc;
    up_raw = 1'b1;
    ticks(19);
    check("s5_pulses_before_reset", count_since(up_q, s), 2);
    reset = 1'b1;
    tick();
    check_all_zero("s5_reset_first");
    tick();
    check_all_zero("s5_reset_second");
    reset = 1'b0;
    r_end = cyc;
    ticks(12);
    up_raw = 1'b0;
    ticks(20);
    check("s5_first_pulse_after_reset", nth_since(up_q, r_end, 0), r_end + 7);

    // 6: 3-cycle glitch on down is rejected.
    s = cyc;
    snap = down_lvl_cnt;
    down_raw = 1'b1;
    ticks(3);
    down_raw = 1'b0;
    ticks(15);
    check("s6_down_pulse_count", count_since(down_q, s), 0);
    check("s6_down_level_cycles", down_lvl_cnt - snap, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
